// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Takes a byte on a one-cycle trmt strobe and
// sends it LSB-first on TX as a start bit (0), 8 data bits and a stop bit (1).
// Each bit lasts BAUD_DIV clk cycles; the default of 2604 gives 38400 baud
// at 100 MHz.
// Optional build macro UART_TX_PARITY_EN: when defined, the frame is 8E1.
// An even-parity bit goes between data bit 7 and the stop bit.
// When it is undefined, the frame is plain 8N1.
module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_busy,
  output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Counter terminal values. The frame ends when the last bit's baud period expires.
  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(FRAME_BITS - 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    TRANSMIT = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [11:0]           baud_cnt_r;
  logic [11:0]           baud_cnt_nxt_s;
  logic [3:0]            bit_cnt_r;
  logic [3:0]            bit_cnt_nxt_s;
  logic [FRAME_BITS-1:0] shift_r;
  logic [FRAME_BITS-1:0] shift_nxt_s;
  logic                  tx_r;
  logic                  tx_nxt_s;
  logic                  busy_r;
  logic                  busy_nxt_s;
  logic                  done_r;
  logic                  done_nxt_s;
  logic                  accept_s;
  logic                  baud_end_s;
  logic                  frame_end_s;

`ifdef UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total number of ones in data+parity even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  // Whole frame as it leaves the shift register, bit 0 first.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] data);
    return {1'b1, even_parity(data), data, 1'b0};
  endfunction
`else
  // Whole frame as it leaves the shift register, bit 0 first.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction
`endif

  assign accept_s    = (state_r == IDLE) && trmt;
  assign baud_end_s  = (state_r == TRANSMIT) && (baud_cnt_r == BAUD_LAST);
  assign frame_end_s = baud_end_s && (bit_cnt_r == BIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a request from IDLE starts a frame; the last bit period ends it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = TRANSMIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TRANSMIT: begin
        if (frame_end_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = TRANSMIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values: load on accept, then count baud and shift right filling with ones.
  always_comb begin
    baud_cnt_nxt_s = baud_cnt_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    shift_nxt_s    = shift_r;
    if (accept_s) begin
      baud_cnt_nxt_s = 12'd0;
      bit_cnt_nxt_s  = 4'd0;
      shift_nxt_s    = frame_of(tx_data);
    end else if (state_r == TRANSMIT) begin
      if (baud_end_s) begin
        baud_cnt_nxt_s = 12'd0;
        bit_cnt_nxt_s  = bit_cnt_r + 4'd1;
        shift_nxt_s    = {1'b1, shift_r[FRAME_BITS-1:1]};
      end else begin
        baud_cnt_nxt_s = baud_cnt_r + 12'd1;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
      end
    end else begin
      baud_cnt_nxt_s = baud_cnt_r;
      bit_cnt_nxt_s  = bit_cnt_r;
      shift_nxt_s    = shift_r;
    end
  end

  // Output logic. The line follows the next shift LSB, so the start bit appears at the accept edge.
  always_comb begin
    tx_nxt_s   = 1'b1;
    busy_nxt_s = 1'b0;
    done_nxt_s = done_r;
    if (state_nxt_s == TRANSMIT) begin
      tx_nxt_s   = shift_nxt_s[0];
      busy_nxt_s = 1'b1;
    end else begin
      tx_nxt_s   = 1'b1;
      busy_nxt_s = 1'b0;
    end
    if (accept_s) begin
      done_nxt_s = 1'b0;
    end else if (frame_end_s) begin
      done_nxt_s = 1'b1;
    end else begin
      done_nxt_s = done_r;
    end
  end

  // Datapath and output registers. Reset forces an idle-high line immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r <= 12'd0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= {FRAME_BITS{1'b1}};
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      baud_cnt_r <= baud_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign TX      = tx_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks uart_tx waveforms bit by bit against hand-written frame
// tables. A line decoder pops expected bytes from a scoreboard queue.
// A short BAUD_DIV keeps every frame brief.
module tb_uart_tx;

  localparam int B = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic [10:0] F_3C = 11'b10001111000;
  localparam logic [10:0] F_01 = 11'b11000000010;
  localparam logic [10:0] F_80 = 11'b11100000000;
  localparam logic [10:0] F_AA = 11'b10101010100;
`else
  localparam int FB = 10;
  localparam logic [10:0] F_3C = 11'b01001111000;
  localparam logic [10:0] F_01 = 11'b01000000010;
  localparam logic [10:0] F_80 = 11'b01100000000;
  localparam logic [10:0] F_AA = 11'b01101010100;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       TX;
  logic       tx_busy;
  logic       tx_done;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         abort_f = 1'b0;
  logic       prev_tx = 1'b1;
  vec_t       vecs[4];

  uart_tx #(.BAUD_DIV(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge rst_n) abort_f = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Called at a negedge: request now (accepted at the next posedge), drop it a half cycle later.
  task automatic launch(input logic [7:0] d, input bit push);
    trmt = 1'b1;
    tx_data = d;
    if (push) exp_q.push_back(d);
    @(negedge clk);
    trmt = 1'b0;
    tx_data = ~d;
  endtask

  // Called at the negedge just after the accept edge; walks the whole frame then checks the end edge.
  task automatic run_frame(input string tag, input logic [10:0] fr, input int inj_k);
    int bad_bus = 0;
    for (int b = 0; b < FB; b++) begin
      logic seen = fr[b];
      for (int c = 0; c < B; c++) begin
        int k = b * B + c;
        if (TX !== fr[b]) seen = TX;
        if (tx_busy !== 1'b1 || tx_done !== 1'b0) bad_bus++;
        if (inj_k >= 0 && k == inj_k) begin
          trmt = 1'b1;
          tx_data = 8'h55;
        end else if (inj_k >= 0 && k == inj_k + 1) begin
          trmt = 1'b0;
          tx_data = 8'h00;
        end
        @(negedge clk);
      end
      check($sformatf("%s bit%0d", tag, b), {31'd0, seen}, {31'd0, fr[b]});
    end
    check({tag, " busy/done during frame"}, bad_bus, 0);
    check({tag, " TX idle at end"}, {31'd0, TX}, 32'd1);
    check({tag, " busy low at end"}, {31'd0, tx_busy}, 32'd0);
    check({tag, " done high at end"}, {31'd0, tx_done}, 32'd1);
  endtask

  // Line decoder: mid-bit sampling like a receiver; compares against the scoreboard.
  initial begin : monitor
    logic [7:0] got;
    logic       start_b;
    logic       stop_b;
    forever begin
      @(negedge clk);
      if (rst_n && prev_tx && !TX) begin
        abort_f = 1'b0;
        repeat (B / 2) @(negedge clk);
        start_b = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          got[i] = TX;
        end
        if (FB == 11) repeat (B) @(negedge clk);
        repeat (B) @(negedge clk);
        stop_b = TX;
        if (!abort_f) begin
          check("rx start bit", {31'd0, start_b}, 32'd0);
          check("rx stop bit", {31'd0, stop_b}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx unexpected frame: got %0h expected none", got);
          end else begin
            check("rx data", {24'd0, got}, {24'd0, exp_q.pop_front()});
          end
        end
      end
      prev_tx = TX;
    end
  end

  initial begin
    int bad;
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hAA, 11'b10101010100};
    vecs[1] = '{8'hEB, 11'b10111010110};
    vecs[2] = '{8'h07, 11'b11000001110};
    vecs[3] = '{8'h03, 11'b10000000110};
`else
    vecs[0] = '{8'hAA, 11'b01101010100};
    vecs[1] = '{8'hEB, 11'b01111010110};
    vecs[2] = '{8'h07, 11'b01000001110};
    vecs[3] = '{8'h03, 11'b01000000110};
`endif

    // Reset state, both while held and after release.
    #23;
    check("reset TX", {31'd0, TX}, 32'd1);
    check("reset busy", {31'd0, tx_busy}, 32'd0);
    check("reset done", {31'd0, tx_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle TX", {31'd0, TX}, 32'd1);
    check("idle busy", {31'd0, tx_busy}, 32'd0);

    // Table frames, each requested in the first idle cycle after the previous one.
    for (int i = 0; i < 4; i++) begin
      launch(vecs[i].data, 1'b1);
      run_frame($sformatf("vec%0d", i), vecs[i].frame, -1);
    end

    // A request in mid-frame must be ignored.
    launch(8'hAA, 1'b1);
    run_frame("ignore", F_AA, 5 * B + 3);
    bad = 0;
    for (int c = 0; c < 3 * B; c++) begin
      if (TX !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b1) bad++;
      @(negedge clk);
    end
    check("ignore no second frame", bad, 0);

    // Asynchronous reset while the line is low in a frame.
    launch(8'h3C, 1'b0);
    repeat (B + 5) @(negedge clk);
    #2;
    check("pre-reset TX low", {31'd0, TX}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async reset TX", {31'd0, TX}, 32'd1);
    check("async reset busy", {31'd0, tx_busy}, 32'd0);
    check("async reset done", {31'd0, tx_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10 * B + 4; c++) begin
      @(negedge clk);
      if (TX !== 1'b1) bad++;
    end
    check("post-reset line idle", bad, 0);
    launch(8'h3C, 1'b1);
    run_frame("after reset", F_3C, -1);

    // trmt held high: two frames with exactly one idle clk between them.
    @(negedge clk);
    trmt = 1'b1;
    tx_data = 8'h01;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    @(negedge clk);
    tx_data = 8'h80;
    run_frame("held1", F_01, -1);
    @(negedge clk);
    trmt = 1'b0;
    run_frame("held2", F_80, -1);

    repeat (2 * B) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
